clock_ratio_meter: RTL and testbench

Measures the period and high time of an asynchronous, slower clock-like signal, in clk_in cycles. Typical sources are the output of the on-chip clock divider or an external reference. It is the receive-side counterpart of the divider: the divider turns a scale into a divided clock, and this block recovers the ratio from a divided clock. Results feed status registers and self-test logic.

---
 rtl/clock_ratio_meter.sv | 107 ++++++++++
 tb/tb_clock_ratio_meter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/clock_ratio_meter.sv
// clock_ratio_meter: measures period and high time of a slow asynchronous signal in clk_in cycles
// Ports:
//   clk_in, nrst     - measurement clock, asynchronous active-low reset
//   sig_in           - signal under measurement (asynchronous)
//   start, cont      - one-shot request, continuous re-arm
//   busy             - FSM not idle
//   valid, timeout   - one-cycle result / abort pulses
//   period, high_time- last rising-to-rising and rising-to-falling intervals
module clock_ratio_meter #(
  parameter int CNT_WIDTH   = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 67108864
) (
  input  logic                 clk_in,
  input  logic                 nrst,
  input  logic                 sig_in,
  input  logic                 start,
  input  logic                 cont,
  output logic                 busy,
  output logic                 valid,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time
);
  typedef enum logic [1:0] {IDLE, ARM, HIGH, LOW} state_t;
  localparam logic [CNT_WIDTH-1:0] LP_ONE   = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] LP_LIMIT = CNT_WIDTH'(TIMEOUT);
  state_t                 r_state, w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt, r_shadow, w_shadow, r_period, r_high;
  logic                   r_busy, r_valid, r_timeout;
  logic                   w_s, w_rise, w_fall, w_limit, w_done, w_abort;
  assign w_s     = r_sync[SYNC_STAGES-1];
  assign w_rise  = w_s & ~r_s_d;
  assign w_fall  = ~w_s & r_s_d;
  assign w_limit = r_cnt == LP_LIMIT;
  // The awaited edge is tested before the limit so an edge in the limit cycle still reports.
  always_comb begin
    w_next   = r_state;
    w_cnt    = r_cnt + LP_ONE;
    w_shadow = r_shadow;
    w_done   = 1'b0;
    w_abort  = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt  = start ? '0 : r_cnt;
        w_next = start ? ARM : IDLE;
      end
      ARM: begin
        if (w_rise) begin
          w_next = HIGH;
          w_cnt  = LP_ONE;
        end else w_abort = w_limit;
      end
      HIGH: begin
        if (w_fall) begin
          w_next   = LOW;
          w_shadow = r_cnt;
        end else w_abort = w_limit;
      end
      LOW: begin
        if (w_rise) begin
          w_done = 1'b1;
          w_next = cont ? HIGH : IDLE;
          w_cnt  = LP_ONE;
        end else w_abort = w_limit;
      end
    endcase
    if (w_abort) begin
      w_next = IDLE;
      w_cnt  = r_cnt;
    end
  end
  always_ff @(posedge clk_in or negedge nrst) begin
    if (!nrst) begin
      r_sync    <= '0;
      r_s_d     <= 1'b0;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_shadow  <= '0;
      r_period  <= '0;
      r_high    <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d     <= w_s;
      r_state   <= w_next;
      r_cnt     <= w_cnt;
      r_shadow  <= w_shadow;
      r_busy    <= w_next != IDLE;
      r_valid   <= w_done;
      r_timeout <= w_abort;
      if (w_done) begin
        r_period <= r_cnt;
        r_high   <= r_shadow;
      end
    end
  end
  assign busy      = r_busy;
  assign valid     = r_valid;
  assign timeout   = r_timeout;
  assign period    = r_period;
  assign high_time = r_high;
endmodule

// File: tb/tb_clock_ratio_meter.sv
// tb_clock_ratio_meter: randomized and directed checks of clock_ratio_meter against a timestamp model
module tb_clock_ratio_meter;
  localparam int W  = 16;
  localparam int S  = 2;
  localparam int TO = 100;
  logic clk_in = 1'b0;
  logic nrst;
  logic sig_in = 1'b0, start = 1'b0, cont = 1'b0;
  logic busy, valid, timeout;
  logic [W-1:0] period, high_time;
  clock_ratio_meter #(.CNT_WIDTH(W), .SYNC_STAGES(S), .TIMEOUT(TO)) dut (
    .clk_in(clk_in), .nrst(nrst), .sig_in(sig_in), .start(start), .cont(cont),
    .busy(busy), .valid(valid), .timeout(timeout), .period(period), .high_time(high_time)
  );
  always #5 clk_in = ~clk_in;
  int n_vec = 0, n_err = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask
  // Model: sig_in as seen by the edge detector is the input delayed by S (and S+1) samples;
  // intervals come from the posedge index of the last reference point.
  logic hist [0:S];
  int   m_mode = 0, p = 0, base = 0, m_high = 0;
  logic exp_busy = 0, exp_valid = 0, exp_to = 0;
  int   exp_period = 0, exp_high = 0;
  task automatic model_reset();
    for (int i = 0; i <= S; i++) hist[i] = 1'b0;
    m_mode = 0; p = 0; base = 0; m_high = 0;
    exp_busy = 0; exp_valid = 0; exp_to = 0; exp_period = 0; exp_high = 0;
  endtask
  task automatic model_step();
    logic rise, fall;
    int el;
    p++;
    rise = hist[S-1] & ~hist[S];
    fall = ~hist[S-1] & hist[S];
    el = p - base;
    exp_valid = 0;
    exp_to = 0;
    case (m_mode)
      0: if (start) begin m_mode = 1; base = p + 1; end
      1: if (rise) begin m_mode = 2; base = p; end
         else if (el == TO) begin exp_to = 1; m_mode = 0; end
      2: if (fall) begin m_mode = 3; m_high = el; end
         else if (el == TO) begin exp_to = 1; m_mode = 0; end
      default: if (rise) begin
           exp_valid = 1; exp_period = el; exp_high = m_high;
           m_mode = cont ? 2 : 0; base = p;
         end else if (el == TO) begin exp_to = 1; m_mode = 0; end
    endcase
    exp_busy = m_mode != 0;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sig_in;
  endtask
  always @(posedge clk_in or negedge nrst)
    if (!nrst) model_reset(); else model_step();
  int cyc = 0, n_valid = 0, n_to = 0, t_busy = 0, t_to = 0;
  int last_p = 0, last_h = 0;
  logic prev_busy = 1'b0;
  task automatic compare_cycle();
    cyc++;
    chk("busy", busy, exp_busy);
    chk("valid", valid, exp_valid);
    chk("timeout", timeout, exp_to);
    chk("period", period, exp_period);
    chk("high_time", high_time, exp_high);
    if (valid) begin n_valid++; last_p = period; last_h = high_time; end
    if (timeout) begin n_to++; t_to = cyc; end
    if (busy && !prev_busy) t_busy = cyc;
    prev_busy = busy;
  endtask
  always @(negedge clk_in) compare_cycle();
  task automatic cyc_in(input logic s, input logic st, input logic ct);
    @(posedge clk_in);
    #1;
    sig_in = s; start = st; cont = ct;
  endtask
  task automatic wave(input int hi, input int lo, input int reps, input logic ct);
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < hi; i++) cyc_in(1'b1, 1'b0, ct);
      for (int i = 0; i < lo; i++) cyc_in(1'b0, 1'b0, ct);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_in(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    int v0, to0, dv;
    nrst = 1'b0;
    for (int i = 0; i < 6; i++) cyc_in(i[0], 1'b0, 1'b0);
    chk("rst_busy", busy, 0);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    @(posedge clk_in); #1 nrst = 1'b1;
    idle(5);
    chk("idle_busy", busy, 0);
    // single shot 5 high / 3 low
    v0 = n_valid;
    cyc_in(1'b0, 1'b1, 1'b0);
    wave(5, 3, 3, 1'b0);
    idle(5);
    chk("shot_count", n_valid - v0, 1);
    chk("shot_period", last_p, 8);
    chk("shot_high", last_h, 5);
    chk("shot_busy", busy, 0);
    // continuous, then a slower signal, then stop
    cyc_in(1'b0, 1'b1, 1'b1);
    wave(4, 6, 5, 1'b1);
    chk("cont_period", last_p, 10);
    chk("cont_high", last_h, 4);
    wave(10, 10, 4, 1'b1);
    chk("cont2_period", last_p, 20);
    chk("cont2_high", last_h, 10);
    wave(10, 10, 3, 1'b0);
    chk("stop_busy", busy, 0);
    // timeout in ARM with sig_in held low
    to0 = n_to;
    cyc_in(1'b0, 1'b1, 1'b0);
    idle(TO + 10);
    chk("to_count", n_to - to0, 1);
    chk("to_latency", t_to - t_busy, TO + 1);
    chk("to_period", period, 20);
    chk("to_high", high_time, 10);
    chk("to_busy", busy, 0);
    // period exactly at the limit reports; one beyond it aborts
    to0 = n_to;
    cyc_in(1'b0, 1'b1, 1'b1);
    wave(50, 50, 2, 1'b1);
    wave(50, 50, 1, 1'b0);
    idle(10);
    chk("edge_wins_period", last_p, TO);
    chk("edge_wins_no_to", n_to - to0, 0);
    cyc_in(1'b0, 1'b1, 1'b0);
    wave(50, 51, 2, 1'b0);
    idle(10);
    chk("limit_to", n_to - to0, 1);
    // divider loopback, scale 6, with a start while busy
    v0 = n_valid;
    dv = 0;
    for (int i = 0; i < 40; i++) begin
      cyc_in(dv < 3, i == 0 || i == 4, 1'b0);
      dv = (dv + 1) % 6;
    end
    idle(5);
    chk("div_count", n_valid - v0, 1);
    chk("div_period", last_p, 6);
    chk("div_high", last_h, 3);
    // reset while HIGH
    cyc_in(1'b0, 1'b1, 1'b0);
    wave(8, 0, 1, 1'b0);
    #1 nrst = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high", high_time, 0);
    idle(3);
    @(posedge clk_in); #1 nrst = 1'b1;
    v0 = n_valid;
    cyc_in(1'b0, 1'b1, 1'b0);
    wave(5, 3, 2, 1'b0);
    idle(5);
    chk("post_rst_count", n_valid - v0, 1);
    chk("post_rst_period", last_p, 8);
    chk("post_rst_high", last_h, 5);
    // randomized waveforms, starts and continuous mode
    for (int k = 0; k < 200; k++) begin
      int hi, lo;
      logic ct;
      ct = 1'($urandom % 2);
      hi = ($urandom % 12 == 0) ? 101 + int'($urandom % 15) : 2 + int'($urandom % 25);
      lo = ($urandom % 12 == 0) ? 101 + int'($urandom % 15) : 2 + int'($urandom % 25);
      cyc_in(1'b0, $urandom % 3 == 0, ct);
      wave(hi, lo, 1, ct);
    end
    idle(TO + 10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
